// File: rtl/code_lock.sv
// Serial combination lock: one code bit per strobe, attempt-based compare against a
// reprogrammable code register, with a timed lockout after repeated wrong attempts.
module code_lock #(
   parameter int                  CODE_LEN       = 3,
   parameter logic [CODE_LEN-1:0] CODE_DEFAULT   = 3'b010,
   parameter int                  MAX_FAILS      = 3,
   parameter int                  LOCKOUT_CYCLES = 16
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           d,
   input  logic                           d_valid,
   input  logic                           relock,
   input  logic                           prog_en,
   input  logic [CODE_LEN-1:0]            prog_code,
   output logic                           unlocked,
   output logic                           locked_out,
   output logic [$clog2(MAX_FAILS+1)-1:0] fail_cnt
);

   localparam int FW = $clog2(MAX_FAILS + 1);
   localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
   localparam int BW = $clog2(CODE_LEN);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ENTRY    = 2'd1,
      UNLOCKED = 2'd2,
      LOCKOUT  = 2'd3
   } state_t;

   state_t              state;
   logic [CODE_LEN-2:0] sr;
   logic [BW-1:0]       bit_cnt;
   logic [CODE_LEN-1:0] code;
   logic [LW-1:0]       lock_cnt;

   logic                attempt_done;
   logic                attempt_ok;
   logic                last_fail;

   assign attempt_done = (bit_cnt == BW'(CODE_LEN - 1));
   assign attempt_ok   = ({sr, d} == code);
   assign last_fail    = (({1'b0, fail_cnt} + 1'b1) == (FW + 1)'(MAX_FAILS));

   // NOTE: all state and outputs update with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         sr         <= '0;
         bit_cnt    <= '0;
         code       <= CODE_DEFAULT;
         lock_cnt   <= '0;
         unlocked   <= 1'b0;
         locked_out <= 1'b0;
         fail_cnt   <= '0;
      end else begin
         case (state)
            IDLE, ENTRY: begin
               if (relock) begin
                  state    <= IDLE;
                  sr       <= '0;
                  bit_cnt  <= '0;
                  fail_cnt <= '0;
               end else if (d_valid) begin
                  if (attempt_done) begin
                     sr      <= '0;
                     bit_cnt <= '0;
                     if (attempt_ok) begin
                        state    <= UNLOCKED;
                        unlocked <= 1'b1;
                        fail_cnt <= '0;
                     end else if (last_fail) begin
                        state      <= LOCKOUT;
                        locked_out <= 1'b1;
                        fail_cnt   <= FW'(MAX_FAILS);
                        lock_cnt   <= LW'(LOCKOUT_CYCLES);
                     end else begin
                        state    <= IDLE;
                        fail_cnt <= fail_cnt + 1'b1;
                     end
                  end else begin
                     // Truncation keeps the newest CODE_LEN-1 bits, also for CODE_LEN=2.
                     sr      <= (CODE_LEN - 1)'({sr, d});
                     bit_cnt <= bit_cnt + 1'b1;
                     state   <= ENTRY;
                  end
               end
            end

            UNLOCKED: begin
               if (relock) begin
                  state    <= IDLE;
                  unlocked <= 1'b0;
                  fail_cnt <= '0;
               end else if (prog_en) begin
                  code <= prog_code;
               end
            end

            LOCKOUT: begin
               if (lock_cnt == LW'(1)) begin
                  state      <= IDLE;
                  locked_out <= 1'b0;
                  fail_cnt   <= '0;
                  lock_cnt   <= '0;
               end else begin
                  lock_cnt <= lock_cnt - 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/code_lock.md
# code_lock

Parametrised serial combination lock: the next generation of the single-code, fixed-length lock FSM. It accepts one code bit per strobed cycle and compares each complete CODE_LEN-bit attempt against a code register that is reprogrammable while unlocked. After MAX_FAILS consecutive wrong attempts it enters a timed lockout. It sits between the keypad/serial-entry front end and the actuator driver, which consumes `unlocked`.

## Interface
- CODE_LEN, 3: code length in bits; legal range 2..16.
- CODE_DEFAULT, 3'b010: code loaded at reset, CODE_LEN bits wide; MSB is the first bit entered.
- MAX_FAILS, 3: consecutive wrong attempts that trigger lockout; legal range 1..15.
- LOCKOUT_CYCLES, 16: lockout duration in clock cycles; must be ≥1.

- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- d  in  1  code bit; sampled only when `d_valid`=1.
- d_valid  in  1  bit strobe; one bit per high cycle.
- relock  in  1  return to locked and discard any partial entry.
- prog_en  in  1  load `prog_code` into the code register; honoured only in UNLOCKED.
- prog_code  in  CODE_LEN  new code, MSB first.
- unlocked  out  1  high while in UNLOCKED.
- locked_out  out  1  high while in LOCKOUT.
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive wrong attempts since the last success, lockout expiry, relock or reset.

## Operation
- Four states:
  - IDLE: locked, no bits held.
  - ENTRY: locked, 1..CODE_LEN-1 bits held.
  - UNLOCKED
  - LOCKOUT
- Internal registers:
  - shift register `sr` (CODE_LEN-1 bits)
  - bit counter (0..CODE_LEN-1)
  - code register
  - lockout down-counter, $clog2(LOCKOUT_CYCLES+1) bits
- Entry is attempt-based, not a sliding detector: an attempt is exactly CODE_LEN strobed bits. No overlap is carried between attempts.
- IDLE/ENTRY behaviour:
  - Each `d_valid` shifts `d` into `sr` LSB and increments the bit counter; the state becomes ENTRY.
  - On the CODE_LEN-th bit, compare {sr, d} with the code register.
  - Match → UNLOCKED; fail_cnt←0.
  - Mismatch with fail_cnt+1 < MAX_FAILS → IDLE; fail_cnt increments.
  - Mismatch with fail_cnt+1 = MAX_FAILS → LOCKOUT; fail_cnt←MAX_FAILS; load the lockout counter with LOCKOUT_CYCLES.
  - The bit counter and `sr` clear at the end of every attempt.
- `relock` in IDLE/ENTRY → IDLE; the partial attempt is discarded and not counted as a fail. `relock` has priority over a coincident `d_valid`.
- UNLOCKED behaviour:
  - `d_valid` is ignored.
  - `prog_en` loads the code register at the next edge.
  - `relock` → IDLE with fail_cnt←0.
  - `relock` and `prog_en` in the same cycle: `relock` wins and the code is unchanged.
  - UNLOCKED is sticky until `relock` or reset.
- LOCKOUT behaviour:
  - `d_valid`, `relock` and `prog_en` are all ignored.
  - The counter decrements each cycle.
  - The cycle it reads 1, the next state is IDLE with fail_cnt←0.
- `prog_en` outside UNLOCKED has no effect.
- Reset (reset_n=0 at a rising edge), including mid-entry or during lockout:
  - state=IDLE, `sr`=0, bit counter=0, lockout counter=0
  - code register=CODE_DEFAULT; a programmed code is lost
  - unlocked=0, locked_out=0, fail_cnt=0

## Timing
- All outputs are registered state decodes and change only at rising edges of `clk`.
- `unlocked` rises at the edge that samples the final matching bit; it is visible the cycle after the strobe.
- `locked_out` rises at the edge that samples the final bit of the MAX_FAILS-th wrong attempt.
- `locked_out` stays high for exactly LOCKOUT_CYCLES cycles. A bit strobed in the first cycle after `locked_out` falls is accepted.
- A code programmed at edge N is used for any attempt that completes after edge N.
- `d_valid` gaps of any length between bits are allowed; there is no inter-bit timeout.
- Back-to-back strobes on consecutive cycles are fully supported.

## Test plan
1. Default code, back-to-back strobes: reset, then d=0,1,0 on consecutive cycles → unlocked=1 from the cycle after the 3rd strobe; fail_cnt=0; locked_out=0.
2. Lockout (MAX_FAILS=3, LOCKOUT_CYCLES=16): three attempts of 0,1,1 →
   - fail_cnt goes 1, 2, then 3 together with locked_out=1;
   - locked_out stays 1 for 16 cycles while d_valid toggles and 0,1,0 is fed, with unlocked=0 throughout;
   - then locked_out=0 and fail_cnt=0, and 0,1,0 unlocks.
3. Reprogramming: unlock with 0,1,0, prog_en with prog_code=101, then relock →
   - 0,1,0 is rejected (fail_cnt=1);
   - 1,0,1 unlocks, with fail_cnt back to 0.
4. Program guards:
   - prog_en with 111 while in IDLE → code stays 010 (0,1,0 still unlocks).
   - relock together with prog_en=101 in UNLOCKED → code stays 010.
5. Reset mid-entry: feed 0,1, then reset_n=0 for one cycle, then 0,1,0 → unlocked rises only after the third post-reset bit, not earlier.
6. Gaps and abandon:
   - 0, (5 idle cycles), 1, (2 idle cycles), 0 → unlocks.
   - 0,1 then relock, then 0,1,0 → unlocks with fail_cnt=0 throughout.
